// File: rtl/ireorder_pkg.sv
// ireorder_pkg: shared widths, last index and FSM encodings for the inverse re-order sequencer
package ireorder_pkg;
  localparam int CNT_WIDTH = 14;
  localparam int MA_WIDTH = 9;
  localparam int BN_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = 14'd16383;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/ireorder_addr_map.sv
// ireorder_addr_map: maps frequency index k to its stored bank, word and sample half
module ireorder_addr_map
  import ireorder_pkg::*;
(
  input  logic [CNT_WIDTH-1:0] k_i,
  output logic [MA_WIDTH-1:0]  ma_o,
  output logic [BN_WIDTH-1:0]  bn_o,
  output logic                 sel_o
);
  logic [CNT_WIDTH-1:0] w_a;
  // radix-16 digit reversal with the radix-4 top digit placed last
  assign w_a = {k_i[3:0], k_i[7:4], k_i[11:8], k_i[13:12]};
  assign ma_o = w_a[13:5];
  assign sel_o = w_a[4];
  // skewed bank sum keeps (bank, word, half) unique for every k
  assign bn_o = k_i[3:0] + k_i[7:4] + k_i[11:8] + {k_i[13:12], 2'b00};
endmodule

// File: rtl/ireorder_addr_ctrl.sv
// ireorder_addr_ctrl: walks k in natural order, issues mapped bank addresses and tracks read return
module ireorder_addr_ctrl
  import ireorder_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 hold_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 addr_vld_o,
  output logic [MA_WIDTH-1:0]  ma_o,
  output logic [BN_WIDTH-1:0]  bn_o,
  output logic                 sel_o,
  output logic                 rd_vld_o,
  output logic [CNT_WIDTH-1:0] idx_o
);
  state_t r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_k;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0][CNT_WIDTH-1:0] r_pk;
  logic [RD_LAT:0] w_pv;
  logic [RD_LAT:0][CNT_WIDTH-1:0] w_pk;
  logic [MA_WIDTH-1:0] w_ma;
  logic [BN_WIDTH-1:0] w_bn;
  logic w_sel;
  logic w_issue;
  logic w_last;
  ireorder_addr_map u_map (
    .k_i  (r_cnt),
    .ma_o (w_ma),
    .bn_o (w_bn),
    .sel_o(w_sel)
  );
  // stage 0 of the delay line is the issued address itself, the top stage is the read return
  assign w_pv = {r_pv, addr_vld_o};
  assign w_pk = {r_pk, r_k};
  assign rd_vld_o = w_pv[RD_LAT];
  assign idx_o = w_pk[RD_LAT];
  assign w_issue = (r_state == RUN) && !hold_i;
  assign w_last = w_pv[RD_LAT-1] && (w_pk[RD_LAT-1] == LAST_IDX);
  // sequencer: issue one mapped address per un-held RUN cycle, finish when the last read returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_k <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      addr_vld_o <= 1'b0;
      ma_o <= '0;
      bn_o <= '0;
      sel_o <= 1'b0;
    end else begin
      addr_vld_o <= w_issue;
      done_o <= 1'b0;
      if (w_issue) begin
        ma_o <= w_ma;
        bn_o <= w_bn;
        sel_o <= w_sel;
        r_k <= r_cnt;
        r_cnt <= r_cnt + 1'b1;
      end
      unique case (r_state)
        IDLE: if (start_i) begin
          r_state <= RUN;
          r_cnt <= '0;
          busy_o <= 1'b1;
        end
        RUN: if (w_issue && r_cnt == LAST_IDX) r_state <= DRAIN;
        DRAIN: if (w_last) begin
          r_state <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // read-latency delay line shifts every cycle regardless of state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_pk <= '0;
    end else begin
      r_pv <= w_pv[RD_LAT-1:0];
      r_pk <= w_pk[RD_LAT-1:0];
    end
  end
endmodule

// File: tb/tb_ireorder_addr_ctrl.sv
// tb_ireorder_addr_ctrl: randomized run-level checks against a behavioural index/latency model
module tb_ireorder_addr_ctrl;
  localparam int RD_LAT = 2;
  localparam int N = 16384;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic hold_i = 1'b0;
  logic busy_o, done_o, addr_vld_o, sel_o, rd_vld_o;
  logic [8:0] ma_o;
  logic [3:0] bn_o;
  logic [13:0] idx_o;
  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int e0;
  int m_next = 0;
  int m_k = 0;
  int m_rk = 0;
  bit m_busy = 0;
  bit m_iss = 0;
  bit m_vld = 0;
  bit m_rv = 0;
  bit m_done = 0;
  bit q_v[$];
  int q_k[$];
  bit seen[N];
  bit uniq_en = 0;
  int uniq = 0;

  ireorder_addr_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .hold_i    (hold_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .addr_vld_o(addr_vld_o),
    .ma_o      (ma_o),
    .bn_o      (bn_o),
    .sel_o     (sel_o),
    .rd_vld_o  (rd_vld_o),
    .idx_o     (idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  function automatic int ref_ma(input int k);
    int a;
    a = (k % 16) * 1024 + ((k / 16) % 16) * 64 + ((k / 256) % 16) * 4 + k / 4096;
    return a / 32;
  endfunction

  function automatic int ref_sel(input int k);
    int a;
    a = (k % 16) * 1024 + ((k / 16) % 16) * 64 + ((k / 256) % 16) * 4 + k / 4096;
    return (a / 16) % 2;
  endfunction

  function automatic int ref_bn(input int k);
    return ((k % 16) + ((k / 16) % 16) + ((k / 256) % 16) + 4 * (k / 4096)) % 16;
  endfunction

  // reference: a run issues k = 0..N-1 in order, skipping held cycles; reads return RD_LAT edges later
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_busy = 0; m_iss = 0; m_vld = 0; m_k = 0; m_next = 0;
      m_rv = 0; m_rk = 0; m_done = 0;
      q_v = {}; q_k = {};
      for (int i = 0; i < RD_LAT; i++) begin
        q_v.push_back(1'b0);
        q_k.push_back(0);
      end
    end else begin
      m_vld = m_iss && !hold_i;
      if (m_vld) begin
        m_k = m_next;
        m_next++;
        if (m_next == N) m_iss = 0;
      end
      q_v.push_back(m_vld);
      q_k.push_back(m_k);
      m_rv = q_v.pop_front();
      m_rk = q_k.pop_front();
      m_done = m_rv && m_rk == N - 1;
      if (!m_busy && start_i) begin
        m_busy = 1; m_iss = 1; m_next = 0;
      end else if (m_done) m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("addr_vld", addr_vld_o, m_vld);
      if (m_vld) begin
        chk("ma", ma_o, ref_ma(m_k));
        chk("bn", bn_o, ref_bn(m_k));
        chk("sel", sel_o, ref_sel(m_k));
        if (m_k == 1) begin
          chk("k1_ma", ma_o, 'h20); chk("k1_sel", sel_o, 0); chk("k1_bn", bn_o, 1);
        end
        if (m_k == 'h10) begin
          chk("k10_ma", ma_o, 'h2); chk("k10_bn", bn_o, 1);
        end
        if (m_k == 'h100) begin
          chk("k100_ma", ma_o, 0); chk("k100_bn", bn_o, 1);
        end
        if (m_k == 'h3000) begin
          chk("k3000_ma", ma_o, 0); chk("k3000_sel", sel_o, 0); chk("k3000_bn", bn_o, 12);
        end
        if (m_k == N - 1) begin
          chk("klast_ma", ma_o, 'h1FF); chk("klast_sel", sel_o, 1); chk("klast_bn", bn_o, 9);
        end
      end
      chk("rd_vld", rd_vld_o, m_rv);
      if (m_rv) chk("idx", idx_o, m_rk);
      if (uniq_en && addr_vld_o) begin
        if (!seen[{bn_o, ma_o, sel_o}]) uniq++;
        seen[{bn_o, ma_o, sel_o}] = 1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_next(input int k, input string tag);
    int n = 0;
    while (m_next != k && n < 20000) begin
      step();
      n++;
    end
    if (n >= 20000) chk(tag, 0, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 20000) begin
      step();
      n++;
    end
    if (n >= 20000) chk(tag, 0, 1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_vld", addr_vld_o, 0);
    chk("rst_rd_vld", rd_vld_o, 0);
    rst = 0;
    step();
    uniq_en = 1;
    start_i = 1; e0 = edge_n + 1;
    step();
    start_i = 0;
    wait_done("timeout_run1");
    chk("lat_nohold", edge_n - e0, N + RD_LAT);
    uniq_en = 0;
    chk("uniq", uniq, N);
    step();
    start_i = 1; e0 = edge_n + 1;
    step();
    start_i = 0;
    wait_next(50, "timeout_k50");
    start_i = 1;
    step();
    start_i = 0;
    wait_next(100, "timeout_k100");
    hold_i = 1;
    repeat (5) step();
    hold_i = 0;
    wait_done("timeout_run2");
    chk("lat_hold5", edge_n - e0, N + RD_LAT + 5);
    start_i = 1;
    step();
    start_i = 0;
    wait_next(8000, "timeout_k8000");
    rst = 1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_vld", addr_vld_o, 0);
    chk("arst_ma", ma_o, 0);
    chk("arst_bn", bn_o, 0);
    chk("arst_sel", sel_o, 0);
    chk("arst_rd_vld", rd_vld_o, 0);
    chk("arst_idx", idx_o, 0);
    step();
    step();
    rst = 0;
    step();
    start_i = 1;
    step();
    start_i = 0;
    for (int n = 0; m_iss && n < 40000; n++) begin
      hold_i = ($urandom_range(0, 7) == 0);
      start_i = ($urandom_range(0, 99) == 0);
      step();
    end
    start_i = 0;
    hold_i = 1;
    wait_done("timeout_run4");
    chk("drain_done", done_o, 1);
    hold_i = 0;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
